// File: rtl/sync_filter.sv
// Multi-bit level synchronizer for asynchronous LP line levels: a flop chain per bit,
// then a consecutive-cycle glitch filter and registered rise/fall pulses.
module sync_filter #(
    parameter int               WIDTH    = 2,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] unstable,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int            CW       = $clog2(FILT_CNT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    logic [WIDTH-1:0] chain_p [STAGES];
    logic [CW-1:0]    cnt     [WIDTH];
    logic [WIDTH-1:0] upd;

    // Synchronizer chain: stage 0 is the metastability capture flop
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                chain_p[s] <= RST_VAL;
            end
        end else begin
            chain_p[0] <= unstable;
            for (int s = 1; s < STAGES; s++) begin
                chain_p[s] <= chain_p[s-1];
            end
        end
    end

    assign sync_out = chain_p[STAGES-1];

    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (sync_out[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Glitch filter: any return to equality restarts the count from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            stable  <= RST_VAL;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((sync_out[i] == stable[i]) || upd[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            stable  <= (stable & ~upd) | (sync_out & upd);
            rise    <= upd & sync_out;
            fall    <= upd & ~sync_out;
            changed <= |upd;
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: default config, a short STAGES=3/FILT_CNT=1 config,
// and a 4-bit config with a non-zero reset value.
module tb_sync_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] ua, sa, sta, ra, fa;
    logic       ca;
    logic [1:0] ub, sb, stb, rb, fb;
    logic       cb;
    logic [3:0] uc, sc, stc, rc, fc;
    logic       cc;

    int nvec = 0;
    int nmis = 0;

    sync_filter #(.WIDTH(2), .STAGES(2), .FILT_CNT(4), .RST_VAL(2'b00)) dut_a (
        .clk(clk), .rst(rst), .unstable(ua), .sync_out(sa), .stable(sta),
        .rise(ra), .fall(fa), .changed(ca));

    sync_filter #(.WIDTH(2), .STAGES(3), .FILT_CNT(1), .RST_VAL(2'b00)) dut_b (
        .clk(clk), .rst(rst), .unstable(ub), .sync_out(sb), .stable(stb),
        .rise(rb), .fall(fb), .changed(cb));

    sync_filter #(.WIDTH(4), .STAGES(2), .FILT_CNT(4), .RST_VAL(4'b0101)) dut_c (
        .clk(clk), .rst(rst), .unstable(uc), .sync_out(sc), .stable(stc),
        .rise(rc), .fall(fc), .changed(cc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp_a;
        rst = 1'b1;
        ua  = 2'b11;
        ub  = 2'b00;
        uc  = 4'b0101;
        for (int e = 1; e <= 2; e++) begin
            tick();
            nvec++;
            if ({sa, sta, ra, fa, ca} !== 9'b0) begin
                nmis++;
                $display("FAIL reset_a e%0d: got %b want %b", e, {sa, sta, ra, fa, ca}, 9'b0);
            end
            nvec++;
            if ({sc, stc, rc, fc, cc} !== {4'b0101, 4'b0101, 8'b0, 1'b0}) begin
                nmis++;
                $display("FAIL reset_c e%0d: got %b want %b", e, {sc, stc, rc, fc, cc},
                         {4'b0101, 4'b0101, 8'b0, 1'b0});
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_a = {(e >= 2) ? 2'b11 : 2'b00, (e >= 6) ? 2'b11 : 2'b00,
                     (e == 6) ? 2'b11 : 2'b00, 2'b00, (e == 6)};
            nvec++;
            if ({sa, sta, ra, fa, ca} !== exp_a) begin
                nmis++;
                $display("FAIL release_a e%0d: got %b want %b", e, {sa, sta, ra, fa, ca}, exp_a);
            end
        end
    endtask

    task automatic test_fall();
        logic [8:0] exp_a;
        ua = 2'b00;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_a = {(e >= 2) ? 2'b00 : 2'b11, (e >= 6) ? 2'b00 : 2'b11, 2'b00,
                     (e == 6) ? 2'b11 : 2'b00, (e == 6)};
            nvec++;
            if ({sa, sta, ra, fa, ca} !== exp_a) begin
                nmis++;
                $display("FAIL fall_a e%0d: got %b want %b", e, {sa, sta, ra, fa, ca}, exp_a);
            end
        end
    endtask

    task automatic test_latency();
        logic [8:0] exp_a;
        ua = 2'b01;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_a = {(e >= 2) ? 2'b01 : 2'b00, (e >= 6) ? 2'b01 : 2'b00,
                     (e == 6) ? 2'b01 : 2'b00, 2'b00, (e == 6)};
            nvec++;
            if ({sa, sta, ra, fa, ca} !== exp_a) begin
                nmis++;
                $display("FAIL latency_a e%0d: got %b want %b", e, {sa, sta, ra, fa, ca}, exp_a);
            end
        end
        ua = 2'b00;
        repeat (8) tick();
    endtask

    task automatic test_glitch();
        // 30 ns high, 10 ns low, 20 ns high on bit 1; index = edge number
        logic [0:12] g = 13'b0111011000000;
        logic [8:0]  exp_a;
        for (int j = 1; j <= 12; j++) begin
            ua = {g[j], 1'b0};
            tick();
            exp_a = {g[j-1], 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            nvec++;
            if ({sa, sta, ra, fa, ca} !== exp_a) begin
                nmis++;
                $display("FAIL glitch_a e%0d: got %b want %b", j, {sa, sta, ra, fa, ca}, exp_a);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp_a;
        ua = 2'b11;
        for (int e = 1; e <= 3; e++) begin
            tick();
            exp_a = {(e >= 2) ? 2'b11 : 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            nvec++;
            if ({sa, sta, ra, fa, ca} !== exp_a) begin
                nmis++;
                $display("FAIL pre_rst_a e%0d: got %b want %b", e, {sa, sta, ra, fa, ca}, exp_a);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if ({sa, sta, ra, fa, ca} !== 9'b0) begin
            nmis++;
            $display("FAIL mid_rst_a: got %b want %b", {sa, sta, ra, fa, ca}, 9'b0);
        end
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_a = {(e >= 2) ? 2'b11 : 2'b00, (e >= 6) ? 2'b11 : 2'b00,
                     (e == 6) ? 2'b11 : 2'b00, 2'b00, (e == 6)};
            nvec++;
            if ({sa, sta, ra, fa, ca} !== exp_a) begin
                nmis++;
                $display("FAIL post_rst_a e%0d: got %b want %b", e, {sa, sta, ra, fa, ca}, exp_a);
            end
        end
    endtask

    task automatic test_fast_latency();
        logic [8:0] exp_b;
        ub = 2'b01;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp_b = {(e >= 3) ? 2'b01 : 2'b00, (e >= 4) ? 2'b01 : 2'b00,
                     (e == 4) ? 2'b01 : 2'b00, 2'b00, (e == 4)};
            nvec++;
            if ({sb, stb, rb, fb, cb} !== exp_b) begin
                nmis++;
                $display("FAIL latency_b e%0d: got %b want %b", e, {sb, stb, rb, fb, cb}, exp_b);
            end
        end
        ub = 2'b00;
        repeat (6) tick();
    endtask

    task automatic test_fast_glitch();
        logic [1:8] gin = 8'b10100000;
        logic [1:8] es  = 8'b00101000;
        logic [1:8] est = 8'b00010100;
        logic [1:8] er  = 8'b00010100;
        logic [1:8] ef  = 8'b00001010;
        logic [8:0] exp_b;
        for (int j = 1; j <= 8; j++) begin
            ub = {gin[j], 1'b0};
            tick();
            exp_b = {es[j], 1'b0, est[j], 1'b0, er[j], 1'b0, ef[j], 1'b0, er[j] | ef[j]};
            nvec++;
            if ({sb, stb, rb, fb, cb} !== exp_b) begin
                nmis++;
                $display("FAIL glitch_b e%0d: got %b want %b", j, {sb, stb, rb, fb, cb}, exp_b);
            end
        end
    endtask

    task automatic test_wide_indep();
        logic [16:0] exp_c;
        uc = 4'b1010;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_c = {(e >= 2) ? 4'b1010 : 4'b0101, (e >= 6) ? 4'b1010 : 4'b0101,
                     (e == 6) ? 4'b1010 : 4'b0000, (e == 6) ? 4'b0101 : 4'b0000, (e == 6)};
            nvec++;
            if ({sc, stc, rc, fc, cc} !== exp_c) begin
                nmis++;
                $display("FAIL indep_c e%0d: got %b want %b", e, {sc, stc, rc, fc, cc}, exp_c);
            end
        end
    endtask

    task automatic test_wide_glitch();
        // bit 2 glitches for 2 cycles while bit 0 makes a real 0->1 transition
        logic [0:10] g2 = 11'b01100000000;
        logic [16:0] exp_c;
        for (int j = 1; j <= 10; j++) begin
            uc = {1'b1, g2[j], 1'b1, 1'b1};
            tick();
            exp_c = {1'b1, g2[j-1], 1'b1, (j >= 2), 3'b101, (j >= 6),
                     3'b000, (j == 6), 4'b0000, (j == 6)};
            nvec++;
            if ({sc, stc, rc, fc, cc} !== exp_c) begin
                nmis++;
                $display("FAIL glitch_c e%0d: got %b want %b", j, {sc, stc, rc, fc, cc}, exp_c);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ua  = 2'b00;
        ub  = 2'b00;
        uc  = 4'b0101;
        test_reset();
        test_fall();
        test_latency();
        test_glitch();
        test_reset_mid();
        test_fast_latency();
        test_fast_glitch();
        test_wide_indep();
        test_wide_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
